// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3, bias 7) constants, arbiter state encoding and operand helpers.
package fp8_pkg;

  localparam int NCH = 4;

  localparam logic [7:0] FP8_NAN  = 8'h7F;
  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_MAXN = 8'h77;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic fp8_is_nan(input logic [7:0] x);
    return (x[6:3] == 4'hF);
  endfunction

  // Exact magnitude in units of 2^-9 (the smallest subnormal step).
  function automatic logic [16:0] fp8_mag(input logic [7:0] x);
    logic [3:0] sig;
    logic [3:0] e;
    sig = {(x[6:3] != 4'd0), x[2:0]};
    e   = (x[6:3] == 4'd0) ? 4'd1 : x[6:3];
    return {13'd0, sig} << (e - 4'd1);
  endfunction

endpackage

// File: rtl/fp8_add_top.sv
// Combinational FP8 E4M3 adder: exact fixed-point sum, then RNE back to E4M3
// with saturation to +/-0x77 and NaN propagation as 0x7F.
module fp8_add_top
  import fp8_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);

  logic [17:0] w_ma, w_mb, w_mag, w_sig_full, w_rem, w_half;
  logic [4:0]  w_p, w_shift, w_sig, w_e;
  logic        w_sign, w_up;

  always_comb begin
    w_ma       = {1'b0, fp8_mag(i_a)};
    w_mb       = {1'b0, fp8_mag(i_b)};
    w_mag      = 18'd0;
    w_sign     = 1'b0;
    w_p        = 5'd0;
    w_shift    = 5'd0;
    w_sig_full = 18'd0;
    w_rem      = 18'd0;
    w_half     = 18'd0;
    w_up       = 1'b0;
    w_sig      = 5'd0;
    w_e        = 5'd0;
    o_y        = FP8_ZERO;
    if (fp8_is_nan(i_a) || fp8_is_nan(i_b)) begin
      o_y = FP8_NAN;
    end else begin
      if (i_a[7] == i_b[7]) begin
        w_mag  = w_ma + w_mb;
        w_sign = i_a[7];
      end else if (w_ma >= w_mb) begin
        w_mag  = w_ma - w_mb;
        w_sign = i_a[7];
      end else begin
        w_mag  = w_mb - w_ma;
        w_sign = i_b[7];
      end
      for (int k = 0; k < 18; k++) begin
        if (w_mag[k]) begin
          w_p = k[4:0];
        end
      end
      if (w_mag == 18'd0) begin
        o_y = {i_a[7] & i_b[7], 7'd0};
      end else if (w_p < 5'd3) begin
        o_y = {w_sign, 4'd0, w_mag[2:0]};
      end else begin
        // Keep a 4-bit significand; round the dropped bits to nearest even.
        w_shift    = w_p - 5'd3;
        w_sig_full = w_mag >> w_shift;
        w_rem      = w_mag & ((18'd1 << w_shift) - 18'd1);
        w_half     = (18'd1 << w_shift) >> 1;
        w_up       = (w_rem > w_half) ||
                     ((w_rem == w_half) && (w_shift != 5'd0) && w_sig_full[0]);
        w_sig      = w_sig_full[4:0] + {4'd0, w_up};
        w_e        = w_p - 5'd2;
        if (w_sig[4]) begin
          w_sig = 5'd8;
          w_e   = w_e + 5'd1;
        end
        if (w_e > 5'd14) begin
          o_y = {w_sign, FP8_MAXN[6:0]};
        end else begin
          o_y = {w_sign, w_e[3:0], w_sig[2:0]};
        end
      end
    end
  end

endmodule

// File: rtl/fp8_add_arbiter.sv
// Round-robin arbiter sharing one FP8 adder among NCH requesters, with
// per-channel accumulators and a response slot held until consumed.
module fp8_add_arbiter #(
  parameter int NCH = fp8_pkg::NCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_valid,
  output logic [NCH-1:0]   req_ready,
  input  logic [8*NCH-1:0] req_a,
  input  logic [8*NCH-1:0] req_b,
  input  logic [NCH-1:0]   req_acc,
  input  logic [NCH-1:0]   acc_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_id,
  output logic [7:0]       rsp_y,
  output logic             busy,
  output logic [8*NCH-1:0] acc_q
);
  import fp8_pkg::*;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, r_id, r_rsp_id, w_win, w_idx;
  logic [7:0] r_a, r_b, r_rsp_y, w_sum;
  logic [7:0] r_acc [NCH];
  logic       r_accf, r_rsp_valid, w_any, w_accept;

  fp8_add_top u_add (
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_sum)
  );

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = r_ptr + k[1:0];
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && w_any && !rst;

  always_comb begin
    req_ready = {NCH{1'b0}};
    if (w_accept) begin
      req_ready[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_a         <= FP8_ZERO;
      r_b         <= FP8_ZERO;
      r_id        <= 2'd0;
      r_accf      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= FP8_ZERO;
      r_rsp_id    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_ptr  <= w_win + 2'd1;
        r_a    <= req_a[{w_win, 3'b000} +: 8];
        r_b    <= req_acc[w_win] ? (acc_clr[w_win] ? FP8_ZERO : r_acc[w_win])
                                 : req_b[{w_win, 3'b000} +: 8];
        r_id   <= w_win;
        r_accf <= req_acc[w_win];
      end
      if (r_state == ST_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_y     <= w_sum;
        r_rsp_id    <= r_id;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // A clear on a channel wins over that channel's writeback in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= FP8_ZERO;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (acc_clr[i]) begin
          r_acc[i] <= FP8_ZERO;
        end else if ((r_state == ST_EXEC) && r_accf && (r_id == i[1:0])) begin
          r_acc[i] <= w_sum;
        end
      end
    end
  end

  always_comb begin
    acc_q = {(8*NCH){1'b0}};
    for (int i = 0; i < NCH; i++) begin
      acc_q[8*i +: 8] = r_acc[i];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Scoreboard bench for fp8_add_arbiter: directed vectors push expected {id,y},
// a negedge monitor pops and compares on every consumed response.
module tb_fp8_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_acc, acc_clr;
  logic [31:0] req_a, req_b, acc_q;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;

  int vectors     = 0;
  int miscompares = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  fp8_add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_acc   (req_acc),
    .acc_clr   (acc_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy),
    .acc_q     (acc_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout, expected DUT event", name);
  endtask

  // Monitor: every consumed response must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got id=%0d y=%h, expected none", rsp_id, rsp_y);
      end else begin
        e = sb_q.pop_front();
        check("rsp_id_y", {22'd0, rsp_id, rsp_y}, {22'd0, e});
      end
    end
  end

  task automatic issue(input int ch, input logic [7:0] a, input logic [7:0] b,
                       input logic acc, input logic clr, input logic [7:0] exp_y,
                       input bit push_exp);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_valid[ch]       = 1'b1;
    req_a[ch*8 +: 8]    = a;
    req_b[ch*8 +: 8]    = b;
    req_acc[ch]         = acc;
    acc_clr[ch]         = clr;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (req_ready[ch]) got = 1'b1;
    end
    if (!got) timeout("grant_wait");
    else if (push_exp) sb_q.push_back({ch[1:0], exp_y});
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    req_acc[ch]   = 1'b0;
    acc_clr[ch]   = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) timeout("idle_wait");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gexp [8];
    int n;
    gexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};

    rst = 1'b1; req_valid = 4'h0; req_acc = 4'h0; acc_clr = 4'h0;
    req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b1;
    #12;
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_y",     {24'd0, rsp_y}, 32'd0);
    check("rst_rsp_id",    {30'd0, rsp_id}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_acc_q",     acc_q, 32'd0);
    req_valid = 4'h0;
    @(negedge clk); rst = 1'b0;

    // Single request and its latency
    issue(0, 8'h38, 8'h38, 1'b0, 1'b0, 8'h40, 1'b1);
    check("lat_edge1_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_edge1_busy",  {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("lat_edge2_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat_edge2_y",     {24'd0, rsp_y}, 32'h40);
    wait_idle();

    // Fairness
    do_reset();
    @(posedge clk); #1;
    req_a = 32'h38383838; req_b = 32'h38383838; req_valid = 4'hF;
    n = 0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        check("grant", {28'd0, req_ready}, 32'd1 << gexp[n]);
        sb_q.push_back({gexp[n], 8'h40});
        n++;
        if (n == 5) begin
          @(posedge clk); #1; req_valid = 4'b0101;
        end else if (n == 8) begin
          @(posedge clk); #1; req_valid = 4'b0000;
        end
      end
    end
    if (n < 8) timeout("fair_grants");
    wait_idle();

    // Accumulate on ch1; B input ignored in acc mode
    issue(1, 8'h38, 8'h55, 1'b1, 1'b0, 8'h38, 1'b1);
    issue(1, 8'h38, 8'h55, 1'b1, 1'b0, 8'h40, 1'b1);
    issue(1, 8'h38, 8'h55, 1'b1, 1'b0, 8'h44, 1'b1);
    wait_idle();
    check("acc_after3", acc_q, 32'h0000_4400);
    @(posedge clk); #1; acc_clr[1] = 1'b1;
    @(posedge clk); #1; acc_clr[1] = 1'b0;
    check("acc_cleared", acc_q, 32'h0);

    // Backpressure, with a competing request that must not be granted
    rsp_ready = 1'b0;
    issue(2, 8'h30, 8'h38, 1'b0, 1'b0, 8'h3C, 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid",     {31'd0, rsp_valid}, 32'd1);
      check("bp_y",         {24'd0, rsp_y}, 32'h3C);
      check("bp_id",        {30'd0, rsp_id}, 32'd2);
      check("bp_req_ready", {28'd0, req_ready}, 32'd0);
      check("bp_busy",      {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0; rsp_ready = 1'b1;
    wait_idle();

    // Specials: NaN stickiness, saturation, cancellation, clear priority
    issue(3, 8'h78, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b1);
    wait_idle();
    check("acc_nan", acc_q, 32'h7F00_0000);
    issue(3, 8'h38, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b1);
    wait_idle();
    check("acc_nan_held", acc_q, 32'h7F00_0000);
    issue(0, 8'h77, 8'h77, 1'b0, 1'b0, 8'h77, 1'b1);
    issue(2, 8'hB8, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1);
    issue(1, 8'hF7, 8'hF7, 1'b0, 1'b0, 8'hF7, 1'b1);
    issue(3, 8'h38, 8'h00, 1'b1, 1'b1, 8'h38, 1'b1);
    wait_idle();
    check("acc_clr_on_accept", acc_q, 32'h3800_0000);
    issue(3, 8'h38, 8'h00, 1'b1, 1'b0, 8'h40, 1'b1);
    acc_clr[3] = 1'b1;
    @(posedge clk); #1; acc_clr[3] = 1'b0;
    wait_idle();
    check("clr_beats_writeback", acc_q, 32'h0);

    // Reset during EXEC: no response, no writeback, pointer back to ch0
    issue(1, 8'h38, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    #2; rst = 1'b1; #1;
    check("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_exec_busy",  {31'd0, busy}, 32'd0);
    check("rst_exec_acc",   acc_q, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    req_a = 32'h38383838; req_b = 32'h38383838; req_valid = 4'b1001;
    @(negedge clk);
    check("post_rst_grant", {28'd0, req_ready}, 32'd1);
    if (req_ready == 4'b0001) sb_q.push_back({2'd0, 8'h40});
    @(posedge clk); #1; req_valid = 4'b0000;
    wait_idle();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp8_add_arbiter.md
FP8_ADD_ARBITER -- requirements
Module: fp8_add_arbiter

Interface
REQ-001 SHALL have parameter: NCH, 4, number of requester channels (fixed 4 in this revision).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  4  per-channel request valid.
REQ-005 SHALL have port: req_ready  output  4  per-channel accept strobe (combinational).
REQ-006 SHALL have port: req_a  input  32  operand A; channel i at bits [8i+7:8i].
REQ-007 SHALL have port: req_b  input  32  operand B, packed the same way as req_a.
REQ-008 SHALL have port: req_acc  input  4  accumulate mode; replaces B with acc[i] and writes the result back to acc[i].
REQ-009 SHALL have port: acc_clr  input  4  synchronous clear of acc[i] to 0x00.
REQ-010 SHALL have port: rsp_valid  output  1  result valid.
REQ-011 SHALL have port: rsp_ready  input  1  result consumed.
REQ-012 SHALL have port: rsp_id  output  2  channel that owns the result.
REQ-013 SHALL have port: rsp_y  output  8  FP8 sum.
REQ-014 SHALL have port: busy  output  1  high when the state is not IDLE.
REQ-015 SHALL have port: acc_q  output  32  packed accumulator contents; channel i at bits [8i+7:8i].

Function
REQ-016 SHALL share one FP8 adder (E4M3, bias 7, exp 15 = NaN 0x7F, saturation to ±0x77, RNE) among all channels, one operation in flight at a time.
REQ-017 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE -> EXEC on any req_valid.
- EXEC -> RESP unconditionally.
- RESP -> IDLE on rsp_ready.
REQ-018 SHALL, in IDLE only, assert req_ready on exactly one channel: the first valid channel at or above the round-robin pointer, searching upward with wrap.
- All other cycles: req_ready = 0.
REQ-019 SHALL, on accept, set the pointer to (winner+1) mod 4 and latch:
- operand A;
- effective B = acc[winner] if req_acc[winner], else req_b;
- winner id and the acc flag.
REQ-020 SHALL, if acc_clr[winner] is high in the accept cycle while in acc mode, use 0x00 as effective B.
REQ-021 SHALL, at the EXEC->RESP edge:
- capture the adder output into rsp_y and the id into rsp_id;
- write the result into acc[id] if the acc flag is set;
- assert rsp_valid. Latency is 2 edges from the accept edge to rsp_valid high.
REQ-022 SHALL hold rsp_valid, rsp_y and rsp_id stable in RESP until rsp_ready; rsp_valid drops at that edge.
- Minimum issue interval is 3 cycles.
REQ-023 SHALL give acc_clr[i] priority over a simultaneous writeback to acc[i].
- acc_clr on other channels never disturbs an in-flight operation.
REQ-024 SHALL hold a NaN (0x7F) in acc[i] until cleared; subsequent acc-mode results on that channel are 0x7F.
REQ-025 SHALL ignore req_valid deassertion after accept; an accepted request always completes.

Reset
REQ-026 SHALL, on rst, immediately force:
- state IDLE, pointer 0;
- rsp_valid 0, rsp_y 0x00, rsp_id 0;
- all acc 0x00, busy 0, req_ready 0.
REQ-027 SHALL abandon any in-flight operation on reset mid-EXEC/RESP, with no accumulator writeback.

Structure
REQ-028 SHALL take from shared package fp8_pkg:
- FP8_NAN = 0x7F, FP8_ZERO = 0x00, FP8_MAXN = 0x77;
- the FSM state encoding and NCH.
REQ-029 SHALL instantiate the existing combinational adder fp8_add_top once, as its only sub-module, driven from the latched operand registers.

Verification
REQ-030 SHALL pass these directed scenarios:
- Single request: ch0 a=0x38, b=0x38 -> rsp_y=0x40, rsp_id=0, rsp_valid 2 edges after accept.
- Fairness: all 4 valid continuously from reset -> grants 0,1,2,3,0; then only ch0 and ch2 valid -> grants alternate 2,0,2.
- Accumulate: ch1 acc mode, a=0x38 three times -> rsp_y 0x38, 0x40, 0x44 and acc_q[15:8]=0x44; acc_clr[1] -> 0x00.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_y/rsp_id stable, req_ready=0, busy=1.
- Specials: a=0x78 -> rsp_y=0x7F and acc holds 0x7F in acc mode; a=b=0x77 -> 0x77; a=0xB8, b=0x38 -> 0x00.
- Reset: rst asserted in EXEC -> rsp_valid=0 without a clock edge, acc unchanged at 0x00, next grant goes to ch0.
